// File: rtl/a51_pkg.sv
// a51_pkg
// Shared definitions for the A5/1 keystream sequencer:
//   - state_t   : sequencer FSM states
//   - R*_LEN    : LFSR lengths (19/22/23)
//   - R*_TAPS   : feedback tap masks
//   - R*_CLK    : clocking-bit positions used by majority clocking
//   - KEY_CYCLES / FRAME_CYCLES : load phase lengths (64 / 22)
//   - maj3()    : 3-input majority helper
package a51_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_FRAME,
    S_MIX,
    S_STREAM,
    S_DONE
  } state_t;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  // Tap masks: R1 {18,17,16,13}, R2 {21,20}, R3 {22,21,20,7}
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  localparam int KEY_CYCLES   = 64;
  localparam int FRAME_CYCLES = 22;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_lfsr_core.sv
// a51_lfsr_core
// The three A5/1 LFSRs with feedback and majority clocking.
// Registers shift toward the MSB; the new bit enters bit 0.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (clears all registers)
//   i_clear     : synchronous clear of all three registers
//   i_clk_en    : advance the registers this cycle
//   i_maj_sel   : 0 = all registers clock, 1 = majority clocking
//   i_inject    : bit XORed into every register's feedback (key/frame loading)
//   o_ks_bit    : keystream bit of the state the registers move to on this edge,
//                 so a "clock then read" sequence yields one bit per edge
module a51_lfsr_core
  import a51_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_clk_en,
  input  logic i_maj_sel,
  input  logic i_inject,
  output logic o_ks_bit
);

  logic [R1_LEN-1:0] r_r1, w_r1_nxt;
  logic [R2_LEN-1:0] r_r2, w_r2_nxt;
  logic [R3_LEN-1:0] r_r3, w_r3_nxt;
  logic              w_maj;
  logic              w_en1, w_en2, w_en3;
  logic              w_fb1, w_fb2, w_fb3;

  always_comb begin
    w_maj = maj3(r_r1[R1_CLK], r_r2[R2_CLK], r_r3[R3_CLK]);
    // In regular mode every register moves; in majority mode only those agreeing with the vote
    w_en1 = ~i_maj_sel | (r_r1[R1_CLK] == w_maj);
    w_en2 = ~i_maj_sel | (r_r2[R2_CLK] == w_maj);
    w_en3 = ~i_maj_sel | (r_r3[R3_CLK] == w_maj);
    w_fb1 = (^(r_r1 & R1_TAPS)) ^ i_inject;
    w_fb2 = (^(r_r2 & R2_TAPS)) ^ i_inject;
    w_fb3 = (^(r_r3 & R3_TAPS)) ^ i_inject;
    w_r1_nxt = w_en1 ? {r_r1[R1_LEN-2:0], w_fb1} : r_r1;
    w_r2_nxt = w_en2 ? {r_r2[R2_LEN-2:0], w_fb2} : r_r2;
    w_r3_nxt = w_en3 ? {r_r3[R3_LEN-2:0], w_fb3} : r_r3;
  end

  assign o_ks_bit = w_r1_nxt[R1_LEN-1] ^ w_r2_nxt[R2_LEN-1] ^ w_r3_nxt[R3_LEN-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
    end else if (i_clear) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
    end else if (i_clk_en) begin
      r_r1 <= w_r1_nxt;
      r_r2 <= w_r2_nxt;
      r_r3 <= w_r3_nxt;
    end
  end

endmodule

// File: rtl/a51_sequencer.sv
// a51_sequencer
// A5/1 key setup and keystream sequencer: loads Kc (64 cycles) and the frame
// number (22 cycles), discards MIX_CYCLES majority-clocked cycles, then packs
// the keystream MSB-first into bytes on a valid/ready stream.
// Parameters: NUM_BYTES (1..28) bytes per frame, MIX_CYCLES (>=1) discard cycles.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   secret_key   : Kc, bit i loaded in key cycle i (latched when start is taken)
//   public_key   : frame number, bit i loaded in frame cycle i (latched with start)
//   start        : begin a key setup, only honoured in IDLE
//   busy         : high in every state except IDLE
//   ks_byte/ks_valid/ks_ready : keystream byte stream (transfer when valid & ready)
//   done         : one-cycle pulse after the frame's last byte is accepted
// Build option: define A51_FRAME_AUTOINC_EN to restart automatically after each
// frame with the latched frame number incremented (mod 2^22), until reset.
module a51_sequencer
  import a51_pkg::*;
#(
  parameter int NUM_BYTES  = 28,
  parameter int MIX_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [KEY_CYCLES-1:0]   secret_key,
  input  logic [FRAME_CYCLES-1:0] public_key,
  input  logic                    start,
  output logic                    busy,
  output logic [7:0]              ks_byte,
  output logic                    ks_valid,
  input  logic                    ks_ready,
  output logic                    done
);

  localparam int PH_W = (MIX_CYCLES > 64) ? 7 : 6;
  localparam logic [PH_W-1:0] PH_KEY_LAST   = PH_W'(KEY_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_FRAME_LAST = PH_W'(FRAME_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_MIX_LAST   = PH_W'(MIX_CYCLES - 1);
  localparam logic [4:0]      BYTE_LAST     = 5'(NUM_BYTES - 1);

  state_t                  r_state;
  logic [PH_W-1:0]         r_phase;
  logic [2:0]              r_bit_cnt;
  logic [4:0]              r_byte_cnt;
  logic [KEY_CYCLES-1:0]   r_key;
  logic [FRAME_CYCLES-1:0] r_frame;
  logic [6:0]              r_shift;
  logic [7:0]              r_ks_byte;
  logic                    r_ks_valid;
  logic                    r_busy;
  logic                    r_done;

  logic w_stall, w_accept, w_clear, w_clk_en, w_maj_sel, w_inject, w_ks_bit;

  assign busy     = r_busy;
  assign ks_byte  = r_ks_byte;
  assign ks_valid = r_ks_valid;
  assign done     = r_done;

  always_comb begin
    // A presented byte that is not taken freezes the whole keystream path
    w_stall   = r_ks_valid & ~ks_ready;
    w_accept  = r_ks_valid & ks_ready;
    w_clear   = 1'b0;
    w_clk_en  = 1'b0;
    w_maj_sel = 1'b0;
    w_inject  = 1'b0;
    case (r_state)
      S_IDLE:       w_clear = start;
      S_LOAD_KEY: begin
        w_clk_en = 1'b1;
        w_inject = r_key[r_phase[5:0]];
      end
      S_LOAD_FRAME: begin
        w_clk_en = 1'b1;
        w_inject = r_frame[r_phase[4:0]];
      end
      S_MIX: begin
        w_clk_en  = 1'b1;
        w_maj_sel = 1'b1;
      end
      S_STREAM: begin
        w_clk_en  = ~w_stall;
        w_maj_sel = 1'b1;
      end
      S_DONE: begin
`ifdef A51_FRAME_AUTOINC_EN
        w_clear = 1'b1;
`else
        w_clear = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  a51_lfsr_core u_core (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_clk_en  (w_clk_en),
    .i_maj_sel (w_maj_sel),
    .i_inject  (w_inject),
    .o_ks_bit  (w_ks_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_key      <= '0;
      r_frame    <= '0;
      r_shift    <= '0;
      r_ks_byte  <= '0;
      r_ks_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_key      <= secret_key;
            r_frame    <= public_key;
            r_phase    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD_KEY;
          end
        end
        S_LOAD_KEY: begin
          if (r_phase == PH_KEY_LAST) begin
            r_phase <= '0;
            r_state <= S_LOAD_FRAME;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_LOAD_FRAME: begin
          if (r_phase == PH_FRAME_LAST) begin
            r_phase <= '0;
            r_state <= S_MIX;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_MIX: begin
          if (r_phase == PH_MIX_LAST) begin
            r_phase <= '0;
            r_state <= S_STREAM;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_STREAM: begin
          if (!w_stall) begin
            r_shift <= {r_shift[5:0], w_ks_bit};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt  <= 3'd0;
              r_ks_byte  <= {r_shift, w_ks_bit};
              r_ks_valid <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              // A byte can only be accepted while the next one is still being packed
              if (w_accept) r_ks_valid <= 1'b0;
            end
            if (w_accept) begin
              if (r_byte_cnt == BYTE_LAST) begin
                r_byte_cnt <= '0;
                r_done     <= 1'b1;
                r_state    <= S_DONE;
              end else begin
                r_byte_cnt <= r_byte_cnt + 5'd1;
              end
            end
          end
        end
        S_DONE: begin
          r_done    <= 1'b0;
          r_bit_cnt <= '0;
          r_phase   <= '0;
`ifdef A51_FRAME_AUTOINC_EN
          r_frame   <= r_frame + 22'd1;
          r_state   <= S_LOAD_KEY;
`else
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a51_sequencer.sv
module tb_a51_sequencer;

  localparam int NB         = 28;
  localparam int MIX        = 100;
  localparam int FIRST_EDGE = 86 + MIX + 8;
  localparam int NVEC       = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] secret_key;
  logic [21:0] public_key;
  logic        start;
  logic        busy;
  logic [7:0]  ks_byte;
  logic        ks_valid;
  logic        ks_ready;
  logic        done;

  a51_sequencer #(.NUM_BYTES(NB), .MIX_CYCLES(MIX)) dut (
    .clk        (clk),
    .reset      (reset),
    .secret_key (secret_key),
    .public_key (public_key),
    .start      (start),
    .busy       (busy),
    .ks_byte    (ks_byte),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] key;
    logic [21:0] frame;
    int          stall_byte;   // 1-based byte to stall on, 0 = none
    int          stall_len;
    int          extra_start;  // cycle after start to pulse start again, 0 = none
    int          abort_at;     // cycle after start to assert reset, 0 = none
    int          exp_first;    // edge of first ks_valid rise, 0 = not expected
    int          exp_bytes;
    int          exp_done;
  } vec_t;

  vec_t vecs[NVEC];

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];

  bit         mon_en = 1'b0;
  int         t0;
  int         n_rise, n_acc, n_done, last_rise, exp_first;
  bit         check_spacing;
  bit         prev_valid, stall_prev;
  logic [7:0] stall_ref;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference A5/1: registers held in 32-bit words, shifted left and masked.
  function automatic logic [31:0] lfsr_step(input logic [31:0] r, input logic [31:0] taps,
                                            input logic [31:0] mask);
    return ((r << 1) & mask) | {31'b0, ^(r & taps)};
  endfunction

  task automatic model_push(input logic [63:0] k, input logic [21:0] f);
    logic [31:0] r1, r2, r3;
    logic        kb, c1, c2, c3, m;
    logic [7:0]  b;
    r1 = 32'h0; r2 = 32'h0; r3 = 32'h0; b = 8'h0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) kb = k[i];
      else        kb = f[i-64];
      r1 = lfsr_step(r1, 32'h0007_2000, 32'h0007_FFFF) ^ {31'b0, kb};
      r2 = lfsr_step(r2, 32'h0030_0000, 32'h003F_FFFF) ^ {31'b0, kb};
      r3 = lfsr_step(r3, 32'h0070_0080, 32'h007F_FFFF) ^ {31'b0, kb};
    end
    for (int i = 0; i < MIX + NB*8; i++) begin
      c1 = r1[8]; c2 = r2[10]; c3 = r3[10];
      m  = (c1 & c2) | (c1 & c3) | (c2 & c3);
      if (c1 == m) r1 = lfsr_step(r1, 32'h0007_2000, 32'h0007_FFFF);
      if (c2 == m) r2 = lfsr_step(r2, 32'h0030_0000, 32'h003F_FFFF);
      if (c3 == m) r3 = lfsr_step(r3, 32'h0070_0080, 32'h007F_FFFF);
      if (i >= MIX) begin
        b = {b[6:0], r1[18] ^ r2[21] ^ r3[22]};
        if (((i - MIX) % 8) == 7) exp_q.push_back(b);
      end
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_valid_held", 64'(ks_valid), 64'(1));
        check("stall_byte_held", 64'(ks_byte), 64'(stall_ref));
      end
      if (ks_valid && !prev_valid) begin
        if (n_rise == 0 && exp_first > 0)
          check("first_valid_edge", 64'(cyc - t0), 64'(exp_first));
        else if (n_rise > 0 && check_spacing)
          check("byte_spacing", 64'(cyc - last_rise), 64'(8));
        last_rise = cyc;
        n_rise++;
      end
      if (ks_valid && ks_ready) begin
        if (exp_q.size() > 0)
          check($sformatf("byte%0d", n_acc), 64'(ks_byte), 64'(exp_q.pop_front()));
        n_acc++;
      end
      if (done) n_done++;
      stall_prev = ks_valid && !ks_ready;
      stall_ref  = ks_byte;
      prev_valid = ks_valid;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int stall_cnt;
    bit finished;
    int rel;
    stall_cnt = 0;
    finished  = 1'b0;
    exp_q.delete();
    model_push(v.key, v.frame);
    n_rise = 0; n_acc = 0; n_done = 0; last_rise = 0;
    prev_valid = 1'b0; stall_prev = 1'b0;
    exp_first = v.exp_first;
    check_spacing = (v.stall_len == 0);

    @(posedge clk); #1;
    secret_key = v.key;
    public_key = v.frame;
    ks_ready   = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    t0     = cyc;
    start  = 1'b0;
    mon_en = 1'b1;
    // Latched copies must be used from here on
    secret_key = {$urandom(), $urandom()};
    public_key = 22'($urandom());

    for (int c = 0; c < 3000 && !finished; c++) begin
      @(posedge clk); #1;
      rel   = cyc - t0;
      start = (v.extra_start > 0 && rel == v.extra_start);
      if (v.abort_at > 0 && rel == v.abort_at) begin
        reset = 1'b1;
        #1;
        check($sformatf("vec%0d_abort_ks_valid", idx), 64'(ks_valid), 64'(0));
        check($sformatf("vec%0d_abort_ks_byte", idx), 64'(ks_byte), 64'(0));
        check($sformatf("vec%0d_abort_busy", idx), 64'(busy), 64'(0));
        check($sformatf("vec%0d_abort_done", idx), 64'(done), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (300) @(posedge clk);
        #1;
        finished = 1'b1;
      end else begin
        if (ks_valid && n_acc == v.stall_byte - 1 && stall_cnt < v.stall_len) begin
          ks_ready = 1'b0;
          stall_cnt++;
        end else begin
          ks_ready = 1'b1;
        end
        if (done) finished = 1'b1;
      end
    end
    check($sformatf("vec%0d_completed", idx), 64'(finished), 64'(1));
    if (finished && v.abort_at == 0) begin
      @(posedge clk); #1;
      check($sformatf("vec%0d_busy_after_done", idx), 64'(busy), 64'(0));
      check($sformatf("vec%0d_done_single", idx), 64'(done), 64'(0));
    end
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check($sformatf("vec%0d_valid_rises", idx), 64'(n_rise), 64'(v.exp_bytes));
    check($sformatf("vec%0d_bytes_accepted", idx), 64'(n_acc), 64'(v.exp_bytes));
    check($sformatf("vec%0d_done_pulses", idx), 64'(n_done), 64'(v.exp_done));
    check($sformatf("vec%0d_idle_busy", idx), 64'(busy), 64'(0));
  endtask

  initial begin
    vecs[0] = '{key: 64'h0, frame: 22'h0, stall_byte: 0, stall_len: 0, extra_start: 0,
                abort_at: 0, exp_first: FIRST_EDGE, exp_bytes: NB, exp_done: 1};
    vecs[1] = '{key: 64'h0123_4567_89AB_CDEF, frame: 22'h000134, stall_byte: 0, stall_len: 0,
                extra_start: 0, abort_at: 0, exp_first: FIRST_EDGE, exp_bytes: NB, exp_done: 1};
    vecs[2] = '{key: 64'hFFFF_FFFF_FFFF_FFFF, frame: 22'h3FFFFF, stall_byte: 0, stall_len: 0,
                extra_start: 0, abort_at: 0, exp_first: FIRST_EDGE, exp_bytes: NB, exp_done: 1};
    vecs[3] = '{key: 64'h0123_4567_89AB_CDEF, frame: 22'h000134, stall_byte: 3, stall_len: 20,
                extra_start: 0, abort_at: 0, exp_first: FIRST_EDGE, exp_bytes: NB, exp_done: 1};
    vecs[4] = '{key: 64'hDEAD_BEEF_CAFE_F00D, frame: 22'h2A5A5, stall_byte: 0, stall_len: 0,
                extra_start: 50, abort_at: 0, exp_first: FIRST_EDGE, exp_bytes: NB, exp_done: 1};
    vecs[5] = '{key: 64'hDEAD_BEEF_CAFE_F00D, frame: 22'h2A5A5, stall_byte: 0, stall_len: 0,
                extra_start: 0, abort_at: 120, exp_first: 0, exp_bytes: 0, exp_done: 0};
    vecs[6] = '{key: 64'hDEAD_BEEF_CAFE_F00D, frame: 22'h2A5A5, stall_byte: 0, stall_len: 0,
                extra_start: 0, abort_at: 0, exp_first: FIRST_EDGE, exp_bytes: NB, exp_done: 1};

    reset      = 1'b1;
    start      = 1'b0;
    ks_ready   = 1'b1;
    secret_key = 64'h0;
    public_key = 22'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ks_valid", 64'(ks_valid), 64'(0));
    check("reset_ks_byte", 64'(ks_byte), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/a51_sequencer.md
A51_SEQUENCER -- requirements
Module: a51_sequencer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 28, keystream bytes delivered per frame (1..28).
REQ-002 SHALL have parameter MIX_CYCLES, default 100, majority-clocked discard cycles before output.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port secret_key, input, 64, session key Kc; bit i is loaded in the i-th key cycle.
REQ-006 SHALL have port public_key, input, 22, frame number; bit i is loaded in the i-th frame cycle.
REQ-007 SHALL have port start, input, 1, request a new key setup; honoured only in IDLE.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have ports ks_byte (output, 8) and ks_valid (output, 1), forming the keystream byte stream.
REQ-010 SHALL have port ks_ready, input, 1, consumer accepts ks_byte when ks_valid and ks_ready are both high.
REQ-011 SHALL have port done, output, 1, single-cycle pulse when the frame's last byte is accepted.

Function
REQ-012 SHALL sample secret_key and public_key into internal registers on the edge that accepts start; later input changes SHALL have no effect.
REQ-013 SHALL implement the LFSRs as follows:
- R1: 19 bits, taps 18,17,16,13, clocking bit 8.
- R2: 22 bits, taps 21,20, clocking bit 10.
- R3: 23 bits, taps 22,21,20,7, clocking bit 10.
- Shift direction: toward the MSB; feedback enters bit 0.
REQ-014 SHALL implement the FSM states IDLE, LOAD_KEY, LOAD_FRAME, MIX, STREAM and DONE.
REQ-015 IDLE SHALL go to LOAD_KEY and clear all LFSRs when start is high.
REQ-016 LOAD_KEY SHALL last 64 cycles and LOAD_FRAME 22 cycles:
- All three LFSRs clock every cycle.
- Input bit per register = feedback XOR the current key or frame bit.
REQ-017 MIX SHALL last MIX_CYCLES cycles with majority clocking:
- A register clocks only when its clocking bit equals the majority of the three clocking bits.
- No output is produced.
REQ-018 STREAM SHALL majority-clock once per cycle:
- Output bit = R1[18]^R2[21]^R3[22].
- Each 8 bits pack MSB-first into ks_byte, then ks_valid is raised.
REQ-019 While ks_valid is high and ks_ready is low, the LFSRs, bit counter, ks_byte and ks_valid SHALL hold.
REQ-020 On acceptance:
- ks_valid SHALL drop in the next cycle.
- Bit packing for the next byte SHALL resume immediately.
- No bubble beyond the 8 shift cycles per byte.
REQ-021 After acceptance of byte NUM_BYTES, the FSM SHALL enter DONE and assert done for exactly one cycle, then return to IDLE.
REQ-022 Timing: counting the start-accepting edge as edge 0, ks_valid SHALL first rise after edge 86+MIX_CYCLES+8 (194 by default).
REQ-023 start while busy SHALL be ignored with no state disturbance.
REQ-024 Counters SHALL be sized exactly: 6-bit phase counter (max 99, 7-bit when MIX_CYCLES>64), 3-bit bit counter, 5-bit byte counter; counters SHALL not wrap beyond their terminal count.

Reset
REQ-025 Asserting reset SHALL immediately force:
- IDLE state; all LFSRs, counters and latched inputs to 0.
- ks_byte=0, ks_valid=0, busy=0, done=0.
REQ-026 Reset mid-operation (any state) SHALL abort the frame; no partial byte SHALL be presented after release.

Configuration
REQ-027 Feature macro A51_FRAME_AUTOINC_EN controls frame-number auto-increment.
- Defined: after the last byte is accepted, DONE pulses done, increments the latched frame number modulo 2^22 and re-enters LOAD_KEY automatically, streaming until reset.
- Undefined: DONE returns to IDLE (REQ-021).

Structure
REQ-028 Shared package a51_pkg SHALL hold:
- The state enumeration.
- Register lengths 19/22/23.
- Tap and clocking-bit positions.
- Phase lengths 64 and 22.
REQ-029 LFSR registers, feedback and majority logic SHALL live in one sub-module a51_lfsr_core, with controls clear, clk_en, regular/majority select and inject bit, and output keystream bit; a51_sequencer holds the FSM, counters and byte packer.

Verification
REQ-030 secret_key=0, public_key=0, start pulse, ks_ready=1 -> 28 bytes all 0x00, done pulses once, busy falls after done.
REQ-031 Any key, ks_ready=1 -> first ks_valid after edge 194, following bytes every 8 cycles, done after byte 28.
REQ-032 ks_ready held low 20 cycles on byte 3 -> ks_byte stable, ks_valid held, and the byte sequence is identical to the no-stall run.
REQ-033 The following vectors SHALL match the a51_pkg-aligned C golden model byte-for-byte:
- key 0x0123456789ABCDEF, frame 0x000134.
- key 0xFFFFFFFFFFFFFFFF, frame 0x3FFFFF.
REQ-034 Reset asserted at cycle 120 (during MIX) -> outputs zero immediately; a new start reproduces the first-run bytes exactly; start pulsed at cycle 50 during busy -> no effect.
REQ-035 With A51_FRAME_AUTOINC_EN, frame 0x3FFFFF -> the second frame uses 0x000000 and done pulses once per frame.
